// File: rtl/piso_if.sv
// Handshake and serial-output bundle between the MRAM read logic, the serializer and the link.
// The master side drives words in; the slave side (the serializer) drives the serial stream.
interface piso_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
);
  localparam int NLANE = DATA_W / LANE_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic [NLANE-1:0]  lane_mask;
  logic              msb_first;
  logic              ser_out;
  logic              ser_valid;
  logic              done;
  logic              busy;

  modport master (
    output in_valid, data_in, lane_mask, msb_first,
    input  in_ready, ser_out, ser_valid, done, busy
  );

  modport slave (
    input  in_valid, data_in, lane_mask, msb_first,
    output in_ready, ser_out, ser_valid, done, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with per-word lane selection, selectable bit order and a
// one-word holding buffer so consecutive words stream out without idle cycles.
module piso_serializer #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  piso_if.slave  bus
);
  localparam int NLANE = DATA_W / LANE_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Packs the selected lanes contiguously so the shifter always drains from one end:
  // toward the top for MSB-first, toward the bottom for LSB-first.
  function automatic logic [DATA_W-1:0] compact(input logic [DATA_W-1:0] d,
                                                input logic [NLANE-1:0]  m,
                                                input logic              msb);
    logic [DATA_W-1:0] r;
    int pos;
    r = '0;
    if (msb) begin
      pos = NLANE - 1;
      for (int i = NLANE - 1; i >= 0; i--) begin
        if (m[i]) begin
          r[pos*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
          pos--;
        end
      end
    end else begin
      pos = 0;
      for (int i = 0; i < NLANE; i++) begin
        if (m[i]) begin
          r[pos*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
          pos++;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] count_bits(input logic [NLANE-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (m[i]) n = n + CNT_W'(LANE_W);
    end
    return n;
  endfunction

  // Holding buffer
  logic              buf_full_p0;
  logic [DATA_W-1:0] buf_data_p0;
  logic [CNT_W-1:0]  buf_nbits_p0;
  logic              buf_msb_p0;

  // Shifter and registered outputs
  state_t            state_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [DATA_W-1:0] sh_data_p1;
  logic              sh_msb_p1;
  logic              ser_out_p1;
  logic              vld_p1;
  logic              done_p1;
  logic              busy_p1;

  logic              in_ready;
  logic              handshake;
  logic              xfer;
  logic              shift_en;

  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ser_out_nxt;
  logic              vld_nxt;
  logic              done_nxt;
  logic              busy_nxt;
  logic              buf_full_nxt;

  assign in_ready  = en & ~buf_full_p0;
  assign handshake = bus.in_valid & in_ready;
  // A transfer happens from IDLE or on the edge right after a word's last bit.
  assign xfer      = en & buf_full_p0 & ((state_p1 == IDLE) | (cnt_p1 == '0));
  assign shift_en  = en & ~xfer & (state_p1 == SHIFT) & (cnt_p1 != '0);

  always_comb begin
    state_nxt    = state_p1;
    cnt_nxt      = cnt_p1;
    ser_out_nxt  = ser_out_p1;
    vld_nxt      = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = busy_p1;
    buf_full_nxt = buf_full_p0;
    if (en) begin
      if (handshake) buf_full_nxt = 1'b1;
      if (xfer) begin
        buf_full_nxt = 1'b0;
        if (buf_nbits_p0 == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt   = SHIFT;
          cnt_nxt     = buf_nbits_p0 - 1'b1;
          ser_out_nxt = buf_msb_p0 ? buf_data_p0[DATA_W-1] : buf_data_p0[0];
          vld_nxt     = 1'b1;
          done_nxt    = (buf_nbits_p0 == CNT_W'(1));
        end
      end else if (state_p1 == SHIFT) begin
        if (cnt_p1 != '0) begin
          cnt_nxt     = cnt_p1 - 1'b1;
          ser_out_nxt = sh_msb_p1 ? sh_data_p1[DATA_W-1] : sh_data_p1[0];
          vld_nxt     = 1'b1;
          done_nxt    = (cnt_p1 == CNT_W'(1));
        end else begin
          state_nxt = IDLE;
        end
      end
      busy_nxt = buf_full_nxt | (state_nxt == SHIFT);
    end
  end

  // Control stage: everything that must come out of reset in a known state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_p0 <= 1'b0;
      state_p1    <= IDLE;
      cnt_p1      <= '0;
      ser_out_p1  <= 1'b0;
      vld_p1      <= 1'b0;
      done_p1     <= 1'b0;
      busy_p1     <= 1'b0;
    end else begin
      buf_full_p0 <= buf_full_nxt;
      state_p1    <= state_nxt;
      cnt_p1      <= cnt_nxt;
      ser_out_p1  <= ser_out_nxt;
      vld_p1      <= vld_nxt;
      done_p1     <= done_nxt;
      busy_p1     <= busy_nxt;
    end
  end

  // Data stage: payload registers, only read while qualified by buf_full_p0 / state_p1
  always_ff @(posedge clk) begin
    if (handshake) begin
      buf_data_p0  <= compact(bus.data_in, bus.lane_mask, bus.msb_first);
      buf_nbits_p0 <= count_bits(bus.lane_mask);
      buf_msb_p0   <= bus.msb_first;
    end
    if (xfer) begin
      sh_data_p1 <= buf_msb_p0 ? (buf_data_p0 << 1) : (buf_data_p0 >> 1);
      sh_msb_p1  <= buf_msb_p0;
    end else if (shift_en) begin
      sh_data_p1 <= sh_msb_p1 ? (sh_data_p1 << 1) : (sh_data_p1 >> 1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out_p1;
  assign bus.ser_valid = vld_p1;
  assign bus.done      = done_p1;
  assign bus.busy      = busy_p1;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bit/done sequences are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT presents ser_valid or done.
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst;
  logic en;

  piso_if #(.DATA_W(16), .LANE_W(8)) bus ();

  piso_serializer #(.DATA_W(16), .LANE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic vld;
    logic bitv;
    logic done;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vbits  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pushes n bits in transmit order (pattern[n-1] first); done expected on the last one.
  task automatic expect_bits(input logic [15:0] pattern, input int n);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e.vld  = 1'b1;
      e.bitv = pattern[i];
      e.done = (i == 0);
      q.push_back(e);
    end
  endtask

  task automatic expect_empty_word();
    exp_t e;
    e.vld  = 1'b0;
    e.bitv = 1'b0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic msb);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.lane_mask = m;
    bus.msb_first = msb;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check("handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain_remaining", q.size(), 32'd0);
  endtask

  task automatic check_idle_after(input string name);
    @(posedge clk);
    #1;
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_ser_valid"}, {31'd0, bus.ser_valid}, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.ser_valid || bus.done)) begin
      checks++;
      if (bus.ser_valid) vbits++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output ser_valid=%0b done=%0b required=none",
                 bus.ser_valid, bus.done);
      end else begin
        e = q.pop_front();
        if (bus.ser_valid !== e.vld || (e.vld && bus.ser_out !== e.bitv) || bus.done !== e.done) begin
          errors++;
          $display("FAIL serial_bit actual vld=%0b bit=%0b done=%0b required vld=%0b bit=%0b done=%0b",
                   bus.ser_valid, bus.ser_out, bus.done, e.vld, e.bitv, e.done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bad;
    int vb0;
    rst           = 1'b1;
    en            = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.lane_mask = '0;
    bus.msb_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out",   {31'd0, bus.ser_out},   32'd0);
    check("rst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("rst_done",      {31'd0, bus.done},      32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    rst = 1'b0;
    en  = 1'b1;
    #1;
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    // Full word, MSB-first
    expect_bits(16'b1010010111000011, 16);
    send(16'hA5C3, 2'b11, 1'b1);
    check("full_busy_after_hs", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      cnt += int'(bus.ser_valid);
    end
    check("full_valid_cycles", cnt, 32'd16);
    drain();
    check_idle_after("full");

    // Lower lane only, LSB-first: 0xC3 -> 1,1,0,0,0,0,1,1
    expect_bits(16'b11000011, 8);
    send(16'hA5C3, 2'b01, 1'b0);
    drain();
    check_idle_after("lsb_lane");

    // Back-to-back: upper lane of 0x00FF, then lower lane of 0x1234
    expect_bits(16'b00000000, 8);
    expect_bits(16'b00110100, 8);
    send(16'h00FF, 2'b10, 1'b1);
    fork
      send(16'h1234, 2'b01, 1'b1);
      begin
        @(posedge clk);
        cnt = 0;
        repeat (16) begin
          @(negedge clk);
          cnt += int'(bus.ser_valid);
        end
      end
    join
    check("b2b_unbroken_cycles", cnt, 32'd16);
    drain();
    check_idle_after("b2b");

    // en dropped for 3 cycles after bit 5
    vb0 = vbits;
    expect_bits(16'b1010010111000011, 16);
    send(16'hA5C3, 2'b11, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    en  = 1'b0;
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ser_valid || bus.in_ready) bad++;
    end
    check("en_low_quiet_cycles", bad, 32'd0);
    en = 1'b1;
    drain();
    check("en_low_total_bits", vbits - vb0, 32'd16);
    check_idle_after("en_low");

    // Empty mask: single done, no bits, then a normal word
    vb0 = vbits;
    expect_empty_word();
    send(16'h1234, 2'b00, 1'b1);
    drain();
    check("empty_mask_bits", vbits - vb0, 32'd0);
    check_idle_after("empty_mask");
    expect_bits(16'b10100101, 8);
    send(16'hA5C3, 2'b10, 1'b1);
    drain();
    check_idle_after("after_empty");

    // Reset at bit 9 with a second word buffered
    vb0 = vbits;
    expect_bits(16'b1010010111000011, 16);
    expect_bits(16'h1234, 16);
    send(16'hA5C3, 2'b11, 1'b1);
    send(16'h1234, 2'b11, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    check("bits_before_rst", vbits - vb0, 32'd9);
    rst = 1'b1;
    #1;
    check("async_rst_ser_out",   {31'd0, bus.ser_out},   32'd0);
    check("async_rst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("async_rst_done",      {31'd0, bus.done},      32'd0);
    check("async_rst_busy",      {31'd0, bus.busy},      32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vb0 = vbits;
    repeat (30) @(posedge clk);
    #1;
    check("no_bits_after_rst", vbits - vb0, 32'd0);
    check("busy_after_rst", {31'd0, bus.busy}, 32'd0);
    check("in_ready_after_abort", {31'd0, bus.in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
